// File: rtl/pulse_gen_pkg.sv
//------------------------------------------------------------------------------
// Module  : pulse_gen_pkg
// Brief   : Shared FSM state encoding and default widths for pulse_width_gen.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pulse_gen_pkg;

    localparam int DEFAULT_CNT_W = 16;
    localparam int DEFAULT_NUM_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_down_cnt.sv
//------------------------------------------------------------------------------
// Module  : pulse_down_cnt
// Brief   : Loadable down-counter with zero flag; saturates at zero.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_down_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    localparam logic [W-1:0] C_ONE = W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - C_ONE;
        end
    end

    assign zero = (value == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_width_gen.sv
//------------------------------------------------------------------------------
// Module  : pulse_width_gen
// Brief   : Burst pulse generator (width/gap/count); optional abort enabled by
//           defining PULSE_GEN_ABORT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_width_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int NUM_W = DEFAULT_NUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] width_in,
    input  logic [CNT_W-1:0] gap_in,
    input  logic [NUM_W-1:0] num_in,
    output logic             pulse_out,
    output logic             busy,
    output logic             done
`ifdef PULSE_GEN_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam logic [CNT_W-1:0] C_ONE_CNT = CNT_W'(1);
    localparam logic [NUM_W-1:0] C_ONE_NUM = NUM_W'(1);

    state_t r_state;
    state_t w_state_n;

    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_gap;
    logic             w_latch;

    logic             w_ph_load;
    logic [CNT_W-1:0] w_ph_val;
    logic             w_ph_dec;
    logic [CNT_W-1:0] w_ph_value;
    logic             w_ph_zero;

    logic             w_pc_load;
    logic [NUM_W-1:0] w_pc_val;
    logic             w_pc_dec;
    logic [NUM_W-1:0] w_pc_value;
    logic             w_pc_zero;

    logic             w_abort;
    logic [CNT_W-1:0] w_gap_m1;

`ifdef PULSE_GEN_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // A zero gap still needs one low cycle to separate pulses.
    assign w_gap_m1 = (r_gap == '0) ? '0 : (r_gap - C_ONE_CNT);

    pulse_down_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_ph_load),
        .load_val (w_ph_val),
        .dec      (w_ph_dec),
        .value    (w_ph_value),
        .zero     (w_ph_zero)
    );

    pulse_down_cnt #(.W(NUM_W)) u_pulse_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_pc_load),
        .load_val (w_pc_val),
        .dec      (w_pc_dec),
        .value    (w_pc_value),
        .zero     (w_pc_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Counters hold remaining cycles minus one, so the zero flag marks the last cycle.
    always_comb begin
        w_state_n = r_state;
        w_latch   = 1'b0;
        w_ph_load = 1'b0;
        w_ph_val  = '0;
        w_ph_dec  = 1'b0;
        w_pc_load = 1'b0;
        w_pc_val  = '0;
        w_pc_dec  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_latch = 1'b1;
                    if ((width_in != '0) && (num_in != '0)) begin
                        w_state_n = HIGH;
                        w_ph_load = 1'b1;
                        w_ph_val  = width_in - C_ONE_CNT;
                        w_pc_load = 1'b1;
                        w_pc_val  = num_in - C_ONE_NUM;
                    end else begin
                        w_state_n = FIN;
                    end
                end
            end
            HIGH: begin
                if (w_abort) begin
                    w_state_n = FIN;
                end else if (w_ph_zero) begin
                    if (w_pc_zero) begin
                        w_state_n = FIN;
                    end else begin
                        w_state_n = LOW;
                        w_ph_load = 1'b1;
                        w_ph_val  = w_gap_m1;
                        w_pc_dec  = 1'b1;
                    end
                end else begin
                    w_ph_dec = 1'b1;
                end
            end
            LOW: begin
                if (w_abort) begin
                    w_state_n = FIN;
                end else if (w_ph_zero) begin
                    w_state_n = HIGH;
                    w_ph_load = 1'b1;
                    w_ph_val  = r_width - C_ONE_CNT;
                end else begin
                    w_ph_dec = 1'b1;
                end
            end
            FIN: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_width <= '0;
            r_gap   <= '0;
        end else if (w_latch) begin
            r_width <= width_in;
            r_gap   <= gap_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            pulse_out <= (w_state_n == HIGH);
            done      <= (w_state_n == FIN);
        end
    end

`ifdef PULSE_GEN_ABORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort && ((r_state == HIGH) || (r_state == LOW));
        end
    end
`endif

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire
